data_mem_arbiter: RTL and testbench

Two-requester arbiter for the single-port data memory. It shares the memory's load/store port between the core's load/store stage and a DMA/debug port. The core path is a zero-latency combinational pass-through whenever the core holds the port. DMA accesses are granted on idle or contested cycles and completed with a one-cycle `dma_ack` pulse. The block sits between the core and `data_mem`, and drives the memory's `addr`, `write_data`, `memwrite`, `memread` and `sign_mask` inputs.

---
 rtl/data_mem_arb_pkg.sv | 18 +
 rtl/data_mem_arb_pick.sv | 46 ++++
 rtl/data_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter: state encoding,
// access field widths and the default contention counter width.
package data_mem_arb_pkg;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_DMA_RESP = 1'b1
  } arb_state_e;

  localparam int SIGN_MASK_W = 4;
  localparam int CNT_W_DEFAULT = 16;
  localparam logic [31:0] LED_ADDR = 32'h0000_2000;

  function automatic logic is_led_addr(input logic [31:0] addr);
    return (addr == LED_ADDR);
  endfunction

endpackage

// File: rtl/data_mem_arb_pick.sv
// Grant decision and round-robin flag update for the data memory arbiter.
// DATA_MEM_ARB_RR_EN enables alternation on contested cycles; otherwise the core always wins.
module data_mem_arb_pick
  import data_mem_arb_pkg::*;
(
  input  arb_state_e state,
  input  logic       core_req,
  input  logic       dma_req,
  input  logic       dma_prio,
  output logic       grant_dma,
  output logic       dma_prio_next
);

`ifdef DATA_MEM_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  // Only S_IDLE can grant; the response cycle always belongs to the core
  always_comb begin
    grant_dma     = 1'b0;
    dma_prio_next = dma_prio;
    case (state)
      S_IDLE: begin
        grant_dma = dma_req & (~core_req | dma_prio);
        if (grant_dma) begin
          dma_prio_next = 1'b0;
        end else if (dma_req & core_req) begin
          dma_prio_next = RR_EN;
        end else begin
          dma_prio_next = dma_prio;
        end
      end
      S_DMA_RESP: begin
        grant_dma     = 1'b0;
        dma_prio_next = dma_prio;
      end
      default: begin
        grant_dma     = 1'b0;
        dma_prio_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single data memory port between the core (zero-latency pass-through)
// and a DMA/debug requester. DATA_MEM_ARB_RR_EN selects round-robin on contested cycles.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
)
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            core_addr,
  input  logic [31:0]            core_wdata,
  input  logic [SIGN_MASK_W-1:0] core_sign_mask,
  input  logic                   core_memread,
  input  logic                   core_memwrite,
  output logic [31:0]            core_rdata,
  output logic                   core_stall,
  input  logic                   dma_req,
  input  logic                   dma_we,
  input  logic [31:0]            dma_addr,
  input  logic [31:0]            dma_wdata,
  input  logic [SIGN_MASK_W-1:0] dma_sign_mask,
  output logic                   dma_ack,
  output logic [31:0]            dma_rdata,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [SIGN_MASK_W-1:0] mem_sign_mask,
  output logic                   mem_memread,
  output logic                   mem_memwrite,
  input  logic [31:0]            mem_read_data,
  output logic [CNT_W-1:0]       contention_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  arb_state_e       state_r;
  arb_state_e       state_nxt_s;
  logic             dma_prio_r;
  logic             dma_prio_nxt_s;
  logic             dma_we_r;
  logic [31:0]      dma_rdata_r;
  logic [CNT_W-1:0] cnt_r;
  logic             core_req_s;
  logic             grant_dma_s;
  logic             mem_rd_s;
  logic             mem_wr_s;

  assign core_req_s = core_memread | core_memwrite;

  data_mem_arb_pick u_pick (
    .state         (state_r),
    .core_req      (core_req_s),
    .dma_req       (dma_req),
    .dma_prio      (dma_prio_r),
    .grant_dma     (grant_dma_s),
    .dma_prio_next (dma_prio_nxt_s)
  );

  // Next-state: a grant always spends exactly one response cycle
  always_comb begin
    state_nxt_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (grant_dma_s) begin
          state_nxt_s = S_DMA_RESP;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_DMA_RESP: state_nxt_s = S_IDLE;
      default:    state_nxt_s = S_IDLE;
    endcase
  end

  // State, priority flag and direction of the in-flight DMA op
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_IDLE;
      dma_prio_r <= 1'b0;
      dma_we_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      dma_prio_r <= dma_prio_nxt_s;
      if (grant_dma_s) begin
        dma_we_r <= dma_we;
      end
    end
  end

  // DMA read data capture at the end of the response cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dma_rdata_r <= 32'h0000_0000;
    end else if ((state_r == S_DMA_RESP) && !dma_we_r) begin
      dma_rdata_r <= mem_read_data;
    end
  end

  // Saturating count of cycles the core lost to the DMA
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (core_stall && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Memory port mux: DMA fields only in its grant cycle, core otherwise
  always_comb begin
    mem_addr      = core_addr;
    mem_wdata     = core_wdata;
    mem_sign_mask = core_sign_mask;
    mem_rd_s      = 1'b0;
    mem_wr_s      = 1'b0;
    if (grant_dma_s) begin
      mem_addr      = dma_addr;
      mem_wdata     = dma_wdata;
      mem_sign_mask = dma_sign_mask;
      mem_rd_s      = ~dma_we;
      mem_wr_s      = dma_we;
    end else begin
      mem_addr      = core_addr;
      mem_wdata     = core_wdata;
      mem_sign_mask = core_sign_mask;
      mem_rd_s      = core_memread;
      mem_wr_s      = core_memwrite;
    end
  end

  // Strobes are gated so nothing reaches memory while reset is held
  assign mem_memread    = reset_n & mem_rd_s;
  assign mem_memwrite   = reset_n & mem_wr_s;
  assign core_rdata     = mem_read_data;
  assign core_stall     = core_req_s & grant_dma_s;
  assign dma_ack        = (state_r == S_DMA_RESP);
  // Read data is forwarded during the ack cycle and held by the register afterwards
  assign dma_rdata      = (dma_ack && !dma_we_r) ? mem_read_data : dma_rdata_r;
  assign contention_cnt = cnt_r;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a behavioural memory and reference model.
module tb_data_mem_arbiter;
  import data_mem_arb_pkg::*;

`ifdef DATA_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [3:0]  core_sign_mask;
  logic        core_memread, core_memwrite, core_stall;
  logic        dma_req, dma_we, dma_ack;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [3:0]  dma_sign_mask;
  logic [31:0] mem_addr, mem_wdata, mem_read_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_memread, mem_memwrite;
  logic [15:0] contention_cnt;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_sign_mask(core_sign_mask),
    .core_memread(core_memread), .core_memwrite(core_memwrite),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_sign_mask(dma_sign_mask), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sign_mask(mem_sign_mask),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_read_data(mem_read_data), .contention_cnt(contention_cnt)
  );

  // Word memory 0x1000..0x10FC plus the LED register in slot 64
  logic [31:0] mem [0:64];

  function automatic int widx(input logic [31:0] a);
    return (a == LED_ADDR) ? 64 : int'(a[7:2]);
  endfunction

  function automatic logic [31:0] iaddr(input int i);
    return (i == 64) ? LED_ADDR : (32'h0000_1000 + 32'(i) * 32'd4);
  endfunction

  always @(posedge clk) begin
    if (mem_memwrite) mem[widx(mem_addr)] <= mem_wdata;
    if (mem_memread)  mem_read_data <= mem[widx(mem_addr)];
  end

  task automatic idle_inputs();
    core_memread = 1'b0; core_memwrite = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
    core_sign_mask = 4'h0; dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0;
    dma_wdata = 32'h0; dma_sign_mask = 4'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset_n = 1'b0; idle_inputs();
    @(negedge clk); reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; idle_inputs(); core_memread = 1'b1; dma_req = 1'b1;
    #12;
    n_tests++; if (dma_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%0h exp=0", dma_ack); end
    n_tests++; if (dma_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%0h exp=0", dma_rdata); end
    n_tests++; if (contention_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got=%0h exp=0", contention_cnt); end
    n_tests++; if ({mem_memread, mem_memwrite} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got=%0b exp=00", {mem_memread, mem_memwrite}); end
    @(negedge clk); reset_n = 1'b1; idle_inputs();
    next_cycle();
  endtask

  task automatic test_core_read();
    core_memwrite = 1'b1; core_addr = 32'h1004; core_wdata = 32'hA5A5_0F0F; core_sign_mask = 4'hF;
    @(negedge clk);
    n_tests++; if (mem_memwrite !== 1'b1 || core_stall !== 1'b0) begin n_fail++; $display("FAIL core_wr got=%0b/%0b exp=1/0", mem_memwrite, core_stall); end
    next_cycle();
    core_memwrite = 1'b0; core_memread = 1'b1;
    @(negedge clk);
    n_tests++; if (mem_memread !== 1'b1 || mem_addr !== 32'h1004 || core_stall !== 1'b0) begin n_fail++; $display("FAIL core_rd_issue got=%0b %0h %0b exp=1 1004 0", mem_memread, mem_addr, core_stall); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_tests++; if (core_rdata !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL core_rdata got=%0h exp=a5a50f0f", core_rdata); end
    n_tests++; if (contention_cnt !== 16'h0) begin n_fail++; $display("FAIL core_cnt got=%0h exp=0", contention_cnt); end
    next_cycle();
  endtask

  task automatic test_dma_write();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h1008; dma_wdata = 32'hDEAD_BEEF; dma_sign_mask = 4'b0111;
    @(negedge clk);
    n_tests++; if (mem_memwrite !== 1'b1 || mem_memread !== 1'b0 || mem_addr !== 32'h1008 || mem_wdata !== 32'hDEAD_BEEF || mem_sign_mask !== 4'b0111) begin
      n_fail++; $display("FAIL dma_wr_issue got=%0b%0b %0h %0h %0h", mem_memwrite, mem_memread, mem_addr, mem_wdata, mem_sign_mask); end
    n_tests++; if (dma_ack !== 1'b0) begin n_fail++; $display("FAIL dma_wr_early_ack got=%0b exp=0", dma_ack); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (dma_ack !== 1'b1 || mem_memwrite !== 1'b0) begin n_fail++; $display("FAIL dma_wr_ack got=%0b/%0b exp=1/0", dma_ack, mem_memwrite); end
    next_cycle();
    idle_inputs(); core_memread = 1'b1; core_addr = 32'h1008;
    @(negedge clk);
    n_tests++; if (dma_ack !== 1'b0) begin n_fail++; $display("FAIL dma_wr_ack_pulse got=%0b exp=0", dma_ack); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_tests++; if (core_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dma_wr_readback got=%0h exp=deadbeef", core_rdata); end
    next_cycle();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = LED_ADDR; dma_wdata = 32'h0000_00A5; dma_sign_mask = 4'hF;
    next_cycle();
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_tests++; if (mem[64] !== 32'h0000_00A5) begin n_fail++; $display("FAIL dma_led got=%0h exp=a5", mem[64]); end
    next_cycle();
  endtask

  task automatic test_dma_read();
    core_memwrite = 1'b1; core_addr = 32'h100C; core_wdata = 32'h1234_5678; core_sign_mask = 4'hF;
    next_cycle();
    idle_inputs(); dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h100C;
    @(negedge clk);
    n_tests++; if (mem_memread !== 1'b1 || mem_addr !== 32'h100C) begin n_fail++; $display("FAIL dma_rd_issue got=%0b %0h exp=1 100c", mem_memread, mem_addr); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (dma_ack !== 1'b1 || dma_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL dma_rd_ack got=%0b %0h exp=1 12345678", dma_ack, dma_rdata); end
    next_cycle();
    idle_inputs(); core_memread = 1'b1; core_addr = 32'h1004;
    @(negedge clk);
    n_tests++; if (dma_ack !== 1'b0 || dma_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL dma_rd_hold1 got=%0b %0h exp=0 12345678", dma_ack, dma_rdata); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_tests++; if (dma_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL dma_rd_hold2 got=%0h exp=12345678", dma_rdata); end
    next_cycle();
  endtask

  task automatic test_contention();
    bit resp, owed, g;
    int cnt;
    pulse_reset();
    resp = 1'b0; owed = 1'b0; cnt = 0;
    for (int i = 0; i < 15; i++) begin
      core_memread = 1'b1; core_addr = 32'h1004;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h100C;
      @(negedge clk);
      g = !resp && RR && owed;
      n_tests++; if (core_stall !== g || dma_ack !== resp || mem_addr !== (g ? 32'h100C : 32'h1004) || contention_cnt !== 16'(cnt)) begin
        n_fail++; $display("FAIL contention cyc=%0d stall=%0b/%0b ack=%0b/%0b addr=%0h cnt=%0d/%0d", i, core_stall, g, dma_ack, resp, mem_addr, contention_cnt, cnt); end
      if (g) begin cnt++; owed = 1'b0; end
      else if (!resp) owed = 1'b1;
      resp = g;
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    n_tests++; if (contention_cnt !== (RR ? 16'd5 : 16'd0)) begin n_fail++; $display("FAIL contention_total got=%0d exp=%0d", contention_cnt, RR ? 5 : 0); end
    next_cycle();
  endtask

  task automatic test_starvation();
    bit resp, owed, pend, creq, g;
    int ack_cyc;
    pulse_reset();
    resp = 1'b0; owed = 1'b0; pend = 1'b1; ack_cyc = -1;
    for (int i = 0; i < 24; i++) begin
      creq = (i < 20);
      core_memread = creq; core_addr = 32'h1010;
      dma_req = pend; dma_we = 1'b1; dma_addr = 32'h1014; dma_wdata = 32'h5555_AAAA;
      @(negedge clk);
      g = pend && !resp && (!creq || (RR && owed));
      n_tests++; if (core_stall !== (creq && g) || dma_ack !== resp || mem_memwrite !== g) begin
        n_fail++; $display("FAIL starve cyc=%0d stall=%0b ack=%0b/%0b wr=%0b/%0b", i, core_stall, dma_ack, resp, mem_memwrite, g); end
      if (dma_ack === 1'b1 && ack_cyc < 0) ack_cyc = i;
      if (resp) pend = 1'b0;
      if (g) owed = 1'b0;
      else if (!resp && creq && pend) owed = 1'b1;
      resp = g;
      next_cycle();
    end
    idle_inputs();
    n_tests++; if (ack_cyc !== (RR ? 2 : 21)) begin n_fail++; $display("FAIL starve_ack_cycle got=%0d exp=%0d", ack_cyc, RR ? 2 : 21); end
  endtask

  task automatic test_reset_in_resp();
    idle_inputs(); dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h100C;
    next_cycle();
    core_memread = 1'b1; core_addr = 32'h1004;
    #1;
    n_tests++; if (dma_ack !== 1'b1) begin n_fail++; $display("FAIL rst_resp_pre_ack got=%0b exp=1", dma_ack); end
    reset_n = 1'b0;
    #1;
    n_tests++; if (dma_ack !== 1'b0 || dma_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_resp_clear got=%0b %0h exp=0 0", dma_ack, dma_rdata); end
    n_tests++; if ({mem_memread, mem_memwrite} !== 2'b00) begin n_fail++; $display("FAIL rst_resp_strobes got=%0b exp=00", {mem_memread, mem_memwrite}); end
    @(negedge clk); idle_inputs();
    @(negedge clk); reset_n = 1'b1;
    next_cycle();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h1018; dma_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    n_tests++; if (dma_ack !== 1'b0 || mem_memwrite !== 1'b1 || mem_addr !== 32'h1018) begin n_fail++; $display("FAIL rst_resp_idle got=%0b %0b %0h exp=0 1 1018", dma_ack, mem_memwrite, mem_addr); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (dma_ack !== 1'b1) begin n_fail++; $display("FAIL rst_resp_reack got=%0b exp=1", dma_ack); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] gold [0:64];
    bit resp, owed, dpend, dwe, creq, crd, cwr, g, cr_valid;
    int didx, cidx, cnt, op;
    logic [31:0] dwd, cwd, pend_val, dr_hold, cr_exp;
    logic [3:0] dmask, cmask;
    logic [31:0] e_addr;
    pulse_reset();
    for (int i = 0; i <= 64; i++) begin
      gold[i] = $urandom;
      core_memwrite = 1'b1; core_addr = iaddr(i); core_wdata = gold[i]; core_sign_mask = 4'hF;
      next_cycle();
    end
    idle_inputs();
    resp = 1'b0; owed = 1'b0; dpend = 1'b0; cnt = 0; dr_hold = 32'h0; cr_valid = 1'b0;
    dwe = 1'b0; didx = 0; dwd = 32'h0; dmask = 4'h0; pend_val = 32'h0; cr_exp = 32'h0;
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 2); crd = (op == 1); cwr = (op == 2); creq = crd || cwr;
      cidx = $urandom_range(0, 64); cwd = $urandom; cmask = 4'($urandom_range(0, 15));
      if (!dpend && $urandom_range(0, 2) == 0) begin
        dpend = 1'b1; dwe = 1'($urandom_range(0, 1)); didx = $urandom_range(0, 64);
        dwd = $urandom; dmask = 4'($urandom_range(0, 15));
      end
      core_memread = crd; core_memwrite = cwr; core_addr = iaddr(cidx); core_wdata = cwd; core_sign_mask = cmask;
      dma_req = dpend; dma_we = dwe; dma_addr = iaddr(didx); dma_wdata = dwd; dma_sign_mask = dmask;
      @(negedge clk);
      g = dpend && !resp && (!creq || (RR && owed));
      if (resp && !dwe) dr_hold = pend_val;
      e_addr = g ? iaddr(didx) : iaddr(cidx);
      n_tests++; if (core_stall !== (creq && g) || dma_ack !== resp || contention_cnt !== 16'(cnt)) begin
        n_fail++; $display("FAIL rand_ctl cyc=%0d stall=%0b ack=%0b/%0b cnt=%0d/%0d", i, core_stall, dma_ack, resp, contention_cnt, cnt); end
      n_tests++; if (mem_addr !== e_addr || mem_memread !== (g ? !dwe : crd) || mem_memwrite !== (g ? dwe : cwr) || mem_sign_mask !== (g ? dmask : cmask)) begin
        n_fail++; $display("FAIL rand_port cyc=%0d addr=%0h/%0h rd=%0b wr=%0b mask=%0h", i, mem_addr, e_addr, mem_memread, mem_memwrite, mem_sign_mask); end
      n_tests++; if (dma_rdata !== dr_hold) begin n_fail++; $display("FAIL rand_dma_rdata cyc=%0d got=%0h exp=%0h", i, dma_rdata, dr_hold); end
      if (cr_valid) begin
        n_tests++; if (core_rdata !== cr_exp) begin n_fail++; $display("FAIL rand_core_rdata cyc=%0d got=%0h exp=%0h", i, core_rdata, cr_exp); end
      end
      cr_valid = 1'b0;
      if (resp) dpend = 1'b0;
      if (g) begin
        pend_val = gold[didx];
        if (dwe) gold[didx] = dwd;
        if (creq) cnt++;
        owed = 1'b0;
      end else begin
        if (crd) begin cr_exp = gold[cidx]; cr_valid = 1'b1; end
        if (cwr) gold[cidx] = cwd;
        if (!resp && creq && dpend) owed = 1'b1;
      end
      resp = g;
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_dma_write();
    test_dma_read();
    test_contention();
    test_starvation();
    test_reset_in_resp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
